// File: rtl/fft_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_serializer_pkg
//  Description : Shared complex sample type and the beat-to-bin mapping used
//                by the FFT frame serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_frame_serializer_pkg;

    localparam int CP_W = 16;

    // One complex FFT output sample, carried bit-exact through the serializer.
    typedef struct packed {
        logic signed [CP_W-1:0] re;
        logic signed [CP_W-1:0] im;
    } complex_product_t;

    // Frequency bin carried on a given lane of a given beat.
    // Adjacent pairing puts (2k, 2k+1) on beat k; split pairing puts (k, k+N/2).
    function automatic int unsigned beat_to_index(
        input int unsigned n,
        input bit          split_halves,
        input int unsigned beat,
        input bit          lane
    );
        if (split_halves)
            return lane ? (beat + n / 2) : beat;
        else
            return 2 * beat + {31'd0, lane};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_serializer_frame_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_serializer_frame_bank
//  Description : One N-entry sample bank. The whole frame is written on a
//                strobe; two entries are read combinationally per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_frame_serializer_frame_bank
    import fft_frame_serializer_pkg::*;
#(
    parameter int N     = 128,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       i_we,
    input  complex_product_t [N-1:0]   i_frame,
    input  logic [IDX_W-1:0]           i_idx0,
    input  logic [IDX_W-1:0]           i_idx1,
    output complex_product_t           o_data0,
    output complex_product_t           o_data1
);

    // Contents are intentionally not reset; validity is tracked by the owner.
    complex_product_t [N-1:0] r_mem;

    // Capture the full parallel frame in one cycle.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem <= i_frame;
    end

    assign o_data0 = r_mem[i_idx0];
    assign o_data1 = r_mem[i_idx1];

endmodule
`default_nettype wire

// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_serializer
//  Description : Ping-pong buffer taking one parallel FFT frame per strobe and
//                streaming it out two complex samples per valid/ready beat.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_frame_serializer
    import fft_frame_serializer_pkg::*;
#(
    parameter int N            = 128,
    parameter int SPLIT_HALVES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  complex_product_t [N-1:0]   frame_in,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic                       frame_dropped,
    output logic                       overflow,
    output complex_product_t           data_out_0,
    output complex_product_t           data_out_1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_first,
    output logic                       out_last
);

    localparam int BEATS  = N / 2;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(N);

    logic [1:0]        r_bank_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [BEAT_W-1:0] r_beat;
    logic              r_overflow;
    logic              r_dropped;

    logic [1:0]        w_full_nxt;
    logic [1:0]        w_we;
    logic              w_frame_ready;
    logic              w_out_valid;
    logic              w_capture;
    logic              w_drop;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_release;
    logic [31:0]       w_beat32;
    logic [IDX_W-1:0]  w_idx0;
    logic [IDX_W-1:0]  w_idx1;
    complex_product_t  w_rd0 [2];
    complex_product_t  w_rd1 [2];

    // Readiness comes only from registered state, so out_ready never reaches it.
    assign w_frame_ready = !r_bank_full[r_wr_bank];
    assign w_out_valid   = r_bank_full[r_rd_bank];
    assign w_capture     = frame_valid && w_frame_ready;
    assign w_drop        = frame_valid && !w_frame_ready;
    assign w_accept      = w_out_valid && out_ready;
    assign w_last_beat   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_release     = w_accept && w_last_beat;

    assign w_beat32 = 32'(r_beat);
    assign w_idx0   = IDX_W'(beat_to_index(N, SPLIT_HALVES != 0, w_beat32, 1'b0));
    assign w_idx1   = IDX_W'(beat_to_index(N, SPLIT_HALVES != 0, w_beat32, 1'b1));

    generate
        for (genvar g = 0; g < 2; g++) begin : g_bank
            assign w_we[g] = w_capture && (r_wr_bank == 1'(g));
            fft_frame_serializer_frame_bank #(
                .N     (N),
                .IDX_W (IDX_W)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_we[g]),
                .i_frame (frame_in),
                .i_idx0  (w_idx0),
                .i_idx1  (w_idx1),
                .o_data0 (w_rd0[g]),
                .o_data1 (w_rd1[g])
            );
        end
    endgenerate

    // Capture sets the write bank's flag and release clears the read bank's;
    // they can only name the same bank when it is both empty and full, which
    // cannot happen, so the two updates never collide.
    always_comb begin
        w_full_nxt = r_bank_full;
        if (w_capture)
            w_full_nxt[r_wr_bank] = 1'b1;
        if (w_release)
            w_full_nxt[r_rd_bank] = 1'b0;
    end

    // Bank ownership, beat position and drop reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_beat      <= '0;
            r_overflow  <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_bank_full <= w_full_nxt;
            r_dropped   <= w_drop;
            if (w_drop)
                r_overflow <= 1'b1;
            if (w_capture)
                r_wr_bank <= !r_wr_bank;
            if (w_release) begin
                r_rd_bank <= !r_rd_bank;
                r_beat    <= '0;
            end else if (w_accept) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Output lanes are zeroed whenever no beat is being offered.
    always_comb begin
        data_out_0 = w_out_valid ? w_rd0[r_rd_bank] : '0;
        data_out_1 = w_out_valid ? w_rd1[r_rd_bank] : '0;
    end

    assign frame_ready   = w_frame_ready;
    assign frame_dropped = r_dropped;
    assign overflow      = r_overflow;
    assign out_valid     = w_out_valid;
    assign out_first     = w_out_valid && (r_beat == '0);
    assign out_last      = w_out_valid && w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_serializer
//  Description : Self-checking bench for fft_frame_serializer. Two instances
//                (adjacent and split pairing) share one stimulus stream and
//                are compared every cycle against a two-deep frame FIFO model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_frame_serializer;
    import fft_frame_serializer_pkg::*;

    localparam int N     = 8;
    localparam int BEATS = N / 2;

    typedef complex_product_t [N-1:0] frame_t;

    typedef struct packed {
        logic             ready;
        logic             dropped;
        logic             ovf;
        logic             valid;
        logic             first;
        logic             last;
        complex_product_t d0;
        complex_product_t d1;
    } snap_t;

    typedef struct packed {
        snap_t s0;
        snap_t s1;
    } pair_t;

    logic   clk;
    logic   reset;
    logic   frame_valid;
    frame_t frame_in;
    logic   out_ready;

    logic             rdy0, drp0, ovf0, vld0, fst0, lst0;
    logic             rdy1, drp1, ovf1, vld1, fst1, lst1;
    complex_product_t a0, b0, a1, b1;

    fft_frame_serializer #(.N(N), .SPLIT_HALVES(0)) u_dut0 (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(rdy0), .frame_dropped(drp0), .overflow(ovf0),
        .data_out_0(a0), .data_out_1(b0), .out_valid(vld0), .out_ready(out_ready),
        .out_first(fst0), .out_last(lst0)
    );

    fft_frame_serializer #(.N(N), .SPLIT_HALVES(1)) u_dut1 (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(rdy1), .frame_dropped(drp1), .overflow(ovf1),
        .data_out_0(a1), .data_out_1(b1), .out_valid(vld1), .out_ready(out_ready),
        .out_first(fst1), .out_last(lst1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two whole frames plus a beat position.
    frame_t m_q[$];
    int     m_beat;
    bit     m_ovf;
    bit     m_drp;

    int n_checks;
    int n_fail;
    int cyc;

    function automatic snap_t model_snap(input int p);
        snap_t s;
        int    i0, i1;
        s         = '0;
        s.ready   = (m_q.size() < 2);
        s.dropped = m_drp;
        s.ovf     = m_ovf;
        s.valid   = (m_q.size() > 0);
        if (s.valid) begin
            s.first = (m_beat == 0);
            s.last  = (m_beat == BEATS - 1);
            if (p == 0) begin
                i0 = 2 * m_beat;
                i1 = 2 * m_beat + 1;
            end else begin
                i0 = m_beat;
                i1 = m_beat + N / 2;
            end
            s.d0 = m_q[0][i0];
            s.d1 = m_q[0][i1];
        end
        return s;
    endfunction

    task automatic model_clock(input logic rst, input logic fv, input frame_t f, input logic ordy);
        bit had_room;
        bit has_data;
        if (rst) begin
            m_q.delete();
            m_beat = 0;
            m_ovf  = 0;
            m_drp  = 0;
        end else begin
            had_room = (m_q.size() < 2);
            has_data = (m_q.size() > 0);
            m_drp    = fv && !had_room;
            if (m_drp)
                m_ovf = 1;
            if (has_data && ordy) begin
                if (m_beat == BEATS - 1) begin
                    void'(m_q.pop_front());
                    m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
            if (fv && had_room)
                m_q.push_back(f);
        end
    endtask

    function automatic pair_t sample_dut();
        pair_t o;
        o.s0 = '{ready: rdy0, dropped: drp0, ovf: ovf0, valid: vld0, first: fst0, last: lst0, d0: a0, d1: b0};
        o.s1 = '{ready: rdy1, dropped: drp1, ovf: ovf1, valid: vld1, first: fst1, last: lst1, d0: a1, d1: b1};
        return o;
    endfunction

    // One clock: drive, predict, sample at the falling edge, then advance model.
    task automatic step(input logic rst, input logic fv, input frame_t f, input logic ordy,
                        output pair_t obs, output pair_t expv);
        reset       = rst;
        frame_valid = fv;
        frame_in    = f;
        out_ready   = ordy;
        expv.s0     = model_snap(0);
        expv.s1     = model_snap(1);
        @(negedge clk);
        obs = sample_dut();
        @(posedge clk);
        model_clock(rst, fv, f, ordy);
        cyc++;
        #1;
    endtask

    function automatic frame_t ramp_frame();
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f[k].re = 16'(k);
            f[k].im = 16'(-k);
        end
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f[k].re = 16'($urandom);
            f[k].im = 16'($urandom);
        end
        return f;
    endfunction

    task automatic test_reset();
        pair_t obs, expv, rst_val;
        rst_val          = '0;
        rst_val.s0.ready = 1'b1;
        rst_val.s1.ready = 1'b1;
        step(1'b0, 1'b0, rand_frame(), 1'b1, obs, expv);
        n_checks++;
        if (obs !== rst_val) begin
            n_fail++;
            $display("FAIL reset_values cycle %0d: got %h expected %h", cyc, obs, rst_val);
        end
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL reset_model cycle %0d: got %h expected %h", cyc, obs, expv);
        end
    endtask

    task automatic test_single_frame();
        pair_t obs, expv;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, i == 0, ramp_frame(), 1'b1, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single_frame cycle %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_backpressure();
        pair_t obs, expv;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i == 0, rand_frame(), (i % 2) == 0, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_overflow();
        pair_t obs, expv;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, i < 3, rand_frame(), i >= 5, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL overflow cycle %0d: got %h expected %h", cyc, obs, expv);
            end
        end
        n_checks++;
        if (obs.s0.ovf !== 1'b1 || obs.s1.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky cycle %0d: got %b%b expected 11", cyc, obs.s0.ovf, obs.s1.ovf);
        end
    endtask

    task automatic test_release_edge();
        pair_t obs, expv;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, (i == 0) || (i == 4), rand_frame(), 1'b1, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL release_edge cycle %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        pair_t obs, expv;
        for (int i = 0; i < 11; i++) begin
            step(i == 3, (i == 0) || (i == 4), rand_frame(), 1'b1, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", cyc, obs, expv);
            end
            if (i == 4) begin
                n_checks++;
                if (obs.s0.valid !== 1'b0 || obs.s0.ready !== 1'b1 || obs.s0.ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_state cycle %0d: got v%b r%b o%b expected v0 r1 o0",
                             cyc, obs.s0.valid, obs.s0.ready, obs.s0.ovf);
                end
            end
        end
    endtask

    task automatic test_random();
        pair_t obs, expv;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, rand_frame(),
                 $urandom_range(0, 3) != 0, obs, expv);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", cyc, obs, expv);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        m_beat      = 0;
        m_ovf       = 0;
        m_drp       = 0;
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_in    = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_release_edge();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
Ping-pong frame buffer that accepts one parallel N-point FFT result frame per strobe and streams it out two complex samples per beat, using a valid/ready handshake. It sits downstream of the FFT engine, which emits a whole bit-corrected frame in one cycle. It is the inverse of the FFT's deserializer stage. It feeds per-subcarrier consumers such as the equalizer and demapper, which take two samples per clock.

Parameters:
N, 128, frame length in complex samples; power of two, 8..4096.
SPLIT_HALVES, 0, beat pairing: 0 gives beat k = (2k, 2k+1); 1 gives beat k = (k, k+N/2).
BEATS, N/2, derived, not overridable; beats per frame.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
frame_in  in  complex_product_t [N-1:0]  parallel frame, index = frequency bin
frame_valid  in  1  one-cycle strobe, frame_in valid
frame_ready  out  1  a bank is free; informational, upstream does not stall
frame_dropped  out  1  one-cycle pulse: frame_valid seen while frame_ready=0
overflow  out  1  sticky drop flag, cleared only by reset
data_out_0  out  complex_product_t  first sample of beat
data_out_1  out  complex_product_t  second sample of beat
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
out_first  out  1  out_valid && beat index == 0
out_last  out  1  out_valid && beat index == BEATS-1

Behaviour:
- State: two banks of N samples, bank_full[1:0], wr_bank, rd_bank, beat counter sized for BEATS, overflow.
- Reset: bank_full=0, wr_bank=rd_bank=0, beat=0, overflow=0. Outputs: frame_ready=1, out_valid=0, out_first=0, out_last=0, frame_dropped=0, data_out_*=0. Bank contents are not reset.
- frame_ready = !bank_full[wr_bank], from registered state only. There is no combinational path from out_ready.
- Capture at edge E when frame_valid && frame_ready:
  - Write the whole frame_in into bank wr_bank.
  - Set bank_full[wr_bank].
  - Toggle wr_bank.
- Drop when frame_valid && !frame_ready:
  - Frame is discarded and no bank changes.
  - frame_dropped=1 for the cycle after E.
  - overflow is set.
- out_valid = bank_full[rd_bank].
- Latency: the first beat is visible in the cycle immediately after the capture edge.
- Data outputs:
  - SPLIT_HALVES=0: data_out_0 = bank[rd_bank][2*beat], data_out_1 = bank[rd_bank][2*beat+1].
  - SPLIT_HALVES=1: data_out_0 = bank[rd_bank][beat], data_out_1 = bank[rd_bank][beat+N/2].
  - Both are forced to 0 whenever out_valid=0.
- Handshake:
  - The beat advances only on out_valid && out_ready.
  - When stalled, data_out_*, out_first and out_last hold stable.
- Last beat accepted (beat==BEATS-1 && out_ready):
  - Clear bank_full[rd_bank], toggle rd_bank, beat=0.
  - If the other bank is full, out_valid stays 1 the next cycle: back-to-back, no bubble.
- Simultaneous capture and release in one cycle:
  - Both updates apply; they always target different bank bits, except in the next case.
  - If both banks are full, the frame is dropped even if the last beat is accepted that same cycle, because frame_ready is registered.
- Drops never corrupt a bank being read.
- Reset mid-stream: both banks are discarded; out_valid=0 the next cycle. The next frame streams from beat 0.
- No arithmetic: samples are passed bit-exact.

Decomposition:
- complex_product_t comes from the existing shared package.
- Add a package function for the beat-to-index mapping, parameterised by N and SPLIT_HALVES, so the bench reuses it.
- Sub-module frame_bank: one N-entry register bank with write-all-on-strobe and a two-index combinational read. Instantiate it twice.
- Top-level holds the bank_full, pointer and beat control.

Test Plan:
1. Single frame, pairing 0:
   - Stimulus: N=8, SPLIT_HALVES=0, frame bin k = (re=k, im=-k), out_ready=1.
   - Response: beats (0,1),(2,3),(4,5),(6,7) starting the cycle after capture. out_first on beat 0, out_last on beat 3. out_valid=0 afterwards with data_out=0.
2. Pairing 1:
   - Stimulus: same frame, SPLIT_HALVES=1.
   - Response: beats (0,4),(1,5),(2,6),(3,7).
3. Backpressure:
   - Stimulus: out_ready pattern 0,1,0,1,...
   - Response: each beat holds stable through its stall cycle; 4 beats complete in 8 cycles with no skips or repeats.
4. Overflow:
   - Stimulus: frames A,B,C on cycles 0,1,2 with out_ready=0.
   - Response: A and B captured. frame_ready=0 at cycle 2, frame_dropped pulses once, overflow=1 and stays set. Raising out_ready then yields 8 contiguous beats, A then B, no bubble.
5. Release-edge arrival:
   - Stimulus: frame B arrives on the same cycle A's last beat is accepted, with the other bank empty.
   - Response: B is captured and B beat 0 follows A beat 3 directly.
6. Reset mid-stream:
   - Stimulus: reset during A's beat 2.
   - Response: next cycle out_valid=0, frame_ready=1, overflow=0. A subsequent frame streams from beat 0 with correct data.
